sync_fifo_ctl: RTL

Parametrised single-clock FIFO that succeeds the basic 4-entry buffer. It is generalised to any depth, including non-power-of-two depths. It adds guarded push/pop, a registered occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between producer/consumer blocks in the FPGA datapath as the standard elastic buffer.

---
 rtl/sync_fifo_ctl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctl.sv
//==============================================================================
// Module      : sync_fifo_ctl
// Description : Single-clock FIFO with show-ahead read. Supports any DEPTH >= 2,
//               including non-power-of-two values. Provides guarded push/pop, a
//               registered occupancy count, programmable almost-full and
//               almost-empty thresholds, and sticky overflow/underflow flags.
//
//               Optional feature macro: FIFO_HWM_EN
//                 When defined, adds a high-water-mark register (hwm) and its
//                 clear input (hwm_clr).
//
// Ports       : clk          - clock, rising edge
//               rst          - synchronous reset, active-high
//               push/datain  - write request and write data
//               pop          - read request
//               dataout      - head-of-queue word (valid while !empty)
//               full/empty   - occupancy == DEPTH / == 0
//               almost_full  - count >= AF_LEVEL
//               almost_empty - count <= AE_LEVEL
//               count        - current occupancy, 0..DEPTH
//               overflow     - sticky: push rejected because full
//               underflow    - sticky: pop while empty
//               hwm_clr/hwm  - (FIFO_HWM_EN only) high-water mark
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_ctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int LOG2DEPTH = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     datain,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dataout,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [LOG2DEPTH:0]   count,
    output logic                 overflow,
`ifdef FIFO_HWM_EN
    input  logic                 hwm_clr,
    output logic [LOG2DEPTH:0]   hwm,
`endif
    output logic                 underflow
);

    localparam logic [LOG2DEPTH-1:0] c_last_ptr = LOG2DEPTH'(DEPTH - 1);
    localparam logic [LOG2DEPTH:0]   c_depth    = (LOG2DEPTH + 1)'(DEPTH);
    localparam logic [LOG2DEPTH:0]   c_af_level = (LOG2DEPTH + 1)'(AF_LEVEL);
    localparam logic [LOG2DEPTH:0]   c_ae_level = (LOG2DEPTH + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]     r_mem [0:DEPTH-1];
    logic [LOG2DEPTH-1:0] r_wr_ptr;
    logic [LOG2DEPTH-1:0] r_rd_ptr;
    logic [LOG2DEPTH:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop_ok;
    logic                 w_push_ok;
    logic [LOG2DEPTH:0]   w_count_nxt;

    // Flags come from the registered count only, so no request input reaches
    // an output without passing through a flop.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is admitted only when a real pop frees a slot in
    // the same cycle.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage is not reset; the reset cycle still blocks the write so a push
    // held across reset leaves nothing behind.
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst) begin
            r_mem[r_wr_ptr] <= datain;
        end
    end

    // Explicit wrap keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_HWM_EN
    logic [LOG2DEPTH:0] r_hwm;

    // Clear reloads with the post-edge occupancy rather than zero so the mark
    // never reads below the current fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm <= '0;
        end else if (hwm_clr) begin
            r_hwm <= w_count_nxt;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign hwm = r_hwm;
`endif

    assign dataout      = r_mem[r_rd_ptr];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire
